synthesizer_frame_stretcher: RTL and testbench
==============================================

Name: synthesizer_frame_stretcher

Overview:
Parametrised successor to the synthesizer input stretcher. Accepts bursty per-channel frames from channelizer_N, with samples indexed 0..NUM_CHANNELS-1 and the final sample flagged last. Buffers up to NUM_FRAMES whole frames and replays them to the synthesizer filter at a fixed cadence of one sample every OUTPUT_INTERVAL cycles. Reports overflow, underflow and index-sequence errors, and masks output when transmit is inactive.

Parameters:
NUM_CHANNELS, 16, channels per frame; power of 2, 4..64
DATA_WIDTH, 22, signed width of each of I and Q
NUM_FRAMES, 4, frame buffer depth; power of 2, 2..16
PREFILL_FRAMES, 2, committed frames required before playback starts; 1..NUM_FRAMES
OUTPUT_INTERVAL, 4, cycles between output samples; >= 2

Ports:
Clk  in  1  clock
Rst_n  in  1  asynchronous active-low reset
Input_valid  in  1  input sample strobe
Input_last  in  1  marks the final sample of a frame
Input_index  in  clog2(NUM_CHANNELS)  channel index of the sample
Input_data  in  2x DATA_WIDTH signed  [0]=I, [1]=Q
Transmit_active  in  1  level; 0 forces zero output data
Output_valid  out  1  output sample strobe
Output_last  out  1  final sample of an output frame
Output_index  out  clog2(NUM_CHANNELS)  channel index of the output sample
Output_data  out  2x DATA_WIDTH signed  output I/Q
Frames_buffered  out  clog2(NUM_FRAMES)+1  count of committed, unreleased frames
Error_overflow  out  1  one-cycle pulse
Error_underflow  out  1  one-cycle pulse
Error_sequence  out  1  one-cycle pulse

Behaviour:
- Reset: all outputs 0. Pointers, counters and cadence counter cleared. State IDLE. Buffer RAM contents are don't-care. Asserting Rst_n low mid-frame discards all frames immediately.
- Storage: a NUM_FRAMES x NUM_CHANNELS RAM of 2*DATA_WIDTH entries. Frame pointers are clog2(NUM_FRAMES)+1 bits wide, with the MSB used to tell full from empty.
- Write side, per frame:
  - Expected index starts at 0 and increments on each accepted sample.
  - If Input_index != expected: pulse Error_sequence, discard the frame, and ignore input until the sample after the next Input_last.
  - Input_last on index NUM_CHANNELS-1 commits the frame (write pointer +1).
  - Input_last on any other index is a sequence error and the frame is discarded.
- Overflow: Input_valid at index 0 while NUM_FRAMES frames are committed pulses Error_overflow once and drops the whole frame. Committed frames are never overwritten.
- Commit and release in the same cycle leave Frames_buffered unchanged.
- Read FSM:
  - IDLE: goes to PREFILL when Transmit_active=1.
  - PREFILL: goes to RUN when Frames_buffered >= PREFILL_FRAMES.
  - RUN: the cadence counter counts 0..OUTPUT_INTERVAL-1. At count 0 one sample is issued.
    - Output index advances 0..NUM_CHANNELS-1, with Output_last on the final index.
    - On the last sample the frame is released (read pointer +1).
  - RUN, empty at frame start: if Frames_buffered=0 at a tick with output index 0, the block pulses Error_underflow and emits zero data with valid/index/last, so cadence is preserved. Underflow is evaluated once per frame; the full zero frame is emitted.
  - RUN, Transmit_active low: Output_data is zeroed. When Transmit_active=0 at a frame end, the FSM returns to IDLE and buffered frames are discarded (read pointer := write pointer).
- Latency: Output_* are registered, 2 cycles after the cadence tick (1 RAM read + 1 output register). Output_valid is high for exactly 1 cycle per OUTPUT_INTERVAL.
- Data passes through unmodified; no arithmetic or width change.

Optional Feature:
- Macro: SYNTH_STRETCHER_STATS_EN.
- When defined: adds outputs Stat_overflow_count, Stat_underflow_count and Stat_sequence_count, each 16 bits. Each increments on its error pulse, saturates at 0xFFFF, and clears on reset.
- When undefined: these ports and their logic are absent, with identical behaviour otherwise.

Test Plan:
All scenarios use NUM_CHANNELS=16, NUM_FRAMES=4, PREFILL_FRAMES=2, OUTPUT_INTERVAL=4.
1. Nominal playback: Transmit_active=1; write frames with I=index, Q=-index every 64 cycles. -> Playback starts after 2 commits. Output_valid every 4th cycle, indices 0..15, Output_last on 15, data matches input exactly, no errors.
2. Overflow: write 5 frames back-to-back before playback starts. -> Frames_buffered saturates at 4. One Error_overflow pulse at index 0 of frame 5. Replayed data is frames 1..4.
3. Underflow: commit 2 frames, then stop input. -> 32 valid samples, then one Error_underflow at the next frame start, followed by 16 zero samples with indices 0..15 and unchanged cadence.
4. Sequence error: frame with index 5 missing (4 followed by 6). -> Error_sequence at the index-6 sample, frame not committed, and the next correct frame is accepted.
5. Transmit gating and reset: deassert Transmit_active mid-frame. -> Data zero for the rest of the frame, then IDLE with Frames_buffered=0. Pulling Rst_n low mid-burst -> all outputs 0 asynchronously, with clean restart after release.
6. With SYNTH_STRETCHER_STATS_EN: run scenarios 2 and 3. -> Stat_overflow_count=1, Stat_underflow_count=1, Stat_sequence_count=0.

Source files
------------

// File: rtl/synthesizer_frame_stretcher.sv
// Frame stretcher: buffers whole channelizer frames and replays them at a fixed cadence.
// Optional error statistics counters are enabled by defining SYNTH_STRETCHER_STATS_EN.
module synthesizer_frame_stretcher #(
    parameter int NUM_CHANNELS    = 16,
    parameter int DATA_WIDTH      = 22,
    parameter int NUM_FRAMES      = 4,
    parameter int PREFILL_FRAMES  = 2,
    parameter int OUTPUT_INTERVAL = 4,
    localparam int IW = $clog2(NUM_CHANNELS),
    localparam int FW = $clog2(NUM_FRAMES),
    localparam int PW = FW + 1
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       Input_valid,
    input  logic                       Input_last,
    input  logic [IW-1:0]              Input_index,
    input  logic [1:0][DATA_WIDTH-1:0] Input_data,
    input  logic                       Transmit_active,
    output logic                       Output_valid,
    output logic                       Output_last,
    output logic [IW-1:0]              Output_index,
    output logic [1:0][DATA_WIDTH-1:0] Output_data,
    output logic [PW-1:0]              Frames_buffered,
    output logic                       Error_overflow,
    output logic                       Error_underflow,
    output logic                       Error_sequence
`ifdef SYNTH_STRETCHER_STATS_EN
    ,
    output logic [15:0]                Stat_overflow_count,
    output logic [15:0]                Stat_underflow_count,
    output logic [15:0]                Stat_sequence_count
`endif
);

    localparam int CW = $clog2(OUTPUT_INTERVAL);
    localparam int AW = FW + IW;
    localparam int SW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREFILL = 2'd1,
        RUN     = 2'd2
    } state_t;

    logic [SW-1:0] mem [NUM_FRAMES*NUM_CHANNELS];
    logic [SW-1:0] rd_q;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic [PW-1:0] fill;

    logic [IW-1:0] exp_idx;
    logic          skip;
    logic          seq_err;
    logic          ovf_err;
    logic          wr_en;
    logic          commit;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cad;
    logic [IW-1:0] out_idx;
    logic          uf_frame;
    logic          tick;
    logic          empty;
    logic          zero_now;
    logic          last_now;
    logic          rel;
    logic          discard;
    logic          uf_pulse;

    logic          s1_valid;
    logic          s1_last;
    logic          s1_zero;
    logic [IW-1:0] s1_idx;

    assign fill            = wr_ptr - rd_ptr;
    assign Frames_buffered = fill;
    assign waddr           = {wr_ptr[FW-1:0], exp_idx};
    assign raddr           = {rd_ptr[FW-1:0], out_idx};
    assign wr_ptr_nxt      = wr_ptr + {{(PW-1){1'b0}}, commit};
    assign rd_ptr_nxt      = discard ? wr_ptr_nxt
                                     : rd_ptr + {{(PW-1){1'b0}}, rel};

    // Write side: check index sequence, refuse new frames when full
    always_comb begin
        seq_err = 1'b0;
        ovf_err = 1'b0;
        wr_en   = 1'b0;
        commit  = 1'b0;
        if (Input_valid && !skip) begin
            if (Input_index != exp_idx) begin
                seq_err = 1'b1;
            end else if (exp_idx == '0 && fill == PW'(NUM_FRAMES)) begin
                ovf_err = 1'b1;
            end else if (Input_last && exp_idx != IW'(NUM_CHANNELS-1)) begin
                seq_err = 1'b1;
            end else begin
                wr_en  = 1'b1;
                commit = Input_last;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr         <= '0;
            exp_idx        <= '0;
            skip           <= 1'b0;
            Error_sequence <= 1'b0;
            Error_overflow <= 1'b0;
        end else begin
            wr_ptr         <= wr_ptr_nxt;
            Error_sequence <= seq_err;
            Error_overflow <= ovf_err;
            if (Input_valid) begin
                if (skip || seq_err || ovf_err) begin
                    skip    <= !Input_last;
                    exp_idx <= '0;
                end else begin
                    exp_idx <= Input_last ? '0 : exp_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[waddr] <= Input_data;
        end
        rd_q <= mem[raddr];
    end

    // Read FSM: an empty buffer at a frame start plays a full zero frame
    always_comb begin
        state_nxt = state;
        tick      = 1'b0;
        rel       = 1'b0;
        discard   = 1'b0;
        uf_pulse  = 1'b0;
        empty     = (fill == '0);
        zero_now  = uf_frame;
        last_now  = (out_idx == IW'(NUM_CHANNELS-1));
        unique case (state)
            IDLE: begin
                if (Transmit_active) state_nxt = PREFILL;
            end
            PREFILL: begin
                if (!Transmit_active) begin
                    state_nxt = IDLE;
                end else if (fill >= PW'(PREFILL_FRAMES)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cad == '0) begin
                    tick = 1'b1;
                    if (out_idx == '0) begin
                        zero_now = empty;
                        uf_pulse = empty;
                    end
                    if (last_now) begin
                        if (!Transmit_active) begin
                            discard   = 1'b1;
                            state_nxt = IDLE;
                        end else if (!zero_now) begin
                            rel = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state           <= IDLE;
            rd_ptr          <= '0;
            cad             <= '0;
            out_idx         <= '0;
            uf_frame        <= 1'b0;
            s1_valid        <= 1'b0;
            s1_last         <= 1'b0;
            s1_zero         <= 1'b0;
            s1_idx          <= '0;
            Output_valid    <= 1'b0;
            Output_last     <= 1'b0;
            Output_index    <= '0;
            Output_data     <= '0;
            Error_underflow <= 1'b0;
        end else begin
            state           <= state_nxt;
            rd_ptr          <= rd_ptr_nxt;
            Error_underflow <= uf_pulse;
            if (state != RUN) begin
                cad     <= '0;
                out_idx <= '0;
            end else begin
                cad <= (cad == CW'(OUTPUT_INTERVAL-1)) ? '0 : cad + 1'b1;
                if (tick) out_idx <= out_idx + 1'b1;
            end
            if (tick && out_idx == '0) uf_frame <= empty;
            s1_valid     <= tick;
            s1_last      <= tick && last_now;
            s1_zero      <= zero_now;
            s1_idx       <= out_idx;
            Output_valid <= s1_valid;
            Output_last  <= s1_valid && s1_last;
            Output_index <= s1_valid ? s1_idx : '0;
            Output_data  <= (s1_valid && !s1_zero && Transmit_active) ? rd_q : '0;
        end
    end

`ifdef SYNTH_STRETCHER_STATS_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Stat_overflow_count  <= '0;
            Stat_underflow_count <= '0;
            Stat_sequence_count  <= '0;
        end else begin
            if (ovf_err && Stat_overflow_count != 16'hFFFF)
                Stat_overflow_count <= Stat_overflow_count + 16'd1;
            if (uf_pulse && Stat_underflow_count != 16'hFFFF)
                Stat_underflow_count <= Stat_underflow_count + 16'd1;
            if (seq_err && Stat_sequence_count != 16'hFFFF)
                Stat_sequence_count <= Stat_sequence_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_synthesizer_frame_stretcher.sv
// Directed testbench for synthesizer_frame_stretcher.
// Stats checks are compiled in when SYNTH_STRETCHER_STATS_EN is defined.
module tb_synthesizer_frame_stretcher;

    localparam int NC = 16;
    localparam int DW = 22;
    localparam int NF = 4;
    localparam int PF = 2;
    localparam int OI = 4;
    localparam int MAXO = 1024;

    logic                Clk = 1'b0;
    logic                Rst_n = 1'b0;
    logic                Input_valid = 1'b0;
    logic                Input_last = 1'b0;
    logic [3:0]          Input_index = '0;
    logic [1:0][DW-1:0]  Input_data = '0;
    logic                Transmit_active = 1'b0;
    logic                Output_valid;
    logic                Output_last;
    logic [3:0]          Output_index;
    logic [1:0][DW-1:0]  Output_data;
    logic [2:0]          Frames_buffered;
    logic                Error_overflow;
    logic                Error_underflow;
    logic                Error_sequence;
`ifdef SYNTH_STRETCHER_STATS_EN
    logic [15:0]         Stat_overflow_count;
    logic [15:0]         Stat_underflow_count;
    logic [15:0]         Stat_sequence_count;
`endif

    int checks = 0;
    int failures = 0;

    int           cyc = 0;
    int           n_out = 0;
    int           n_ovf = 0;
    int           n_uf = 0;
    int           n_seq = 0;
    int           uf_cyc = 0;
    logic [3:0]   o_idx [MAXO];
    logic         o_last [MAXO];
    logic [DW-1:0] o_i [MAXO];
    logic [DW-1:0] o_q [MAXO];
    int           o_cyc [MAXO];

    synthesizer_frame_stretcher #(
        .NUM_CHANNELS(NC),
        .DATA_WIDTH(DW),
        .NUM_FRAMES(NF),
        .PREFILL_FRAMES(PF),
        .OUTPUT_INTERVAL(OI)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .Input_valid(Input_valid),
        .Input_last(Input_last),
        .Input_index(Input_index),
        .Input_data(Input_data),
        .Transmit_active(Transmit_active),
        .Output_valid(Output_valid),
        .Output_last(Output_last),
        .Output_index(Output_index),
        .Output_data(Output_data),
        .Frames_buffered(Frames_buffered),
        .Error_overflow(Error_overflow),
        .Error_underflow(Error_underflow),
        .Error_sequence(Error_sequence)
`ifdef SYNTH_STRETCHER_STATS_EN
        ,
        .Stat_overflow_count(Stat_overflow_count),
        .Stat_underflow_count(Stat_underflow_count),
        .Stat_sequence_count(Stat_sequence_count)
`endif
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc++;

    always @(negedge Clk) begin
        if (Output_valid && n_out < MAXO) begin
            o_idx[n_out]  = Output_index;
            o_last[n_out] = Output_last;
            o_i[n_out]    = Output_data[0];
            o_q[n_out]    = Output_data[1];
            o_cyc[n_out]  = cyc;
            n_out++;
        end
        if (Error_overflow) n_ovf++;
        if (Error_sequence) n_seq++;
        if (Error_underflow) begin
            n_uf++;
            uf_cyc = cyc;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        Rst_n = 1'b0;
        Input_valid = 1'b0;
        Input_last = 1'b0;
        Input_index = '0;
        Input_data = '0;
        Transmit_active = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Rst_n = 1'b1;
    endtask

    task automatic send_frame(input int base, input int drop);
        for (int i = 0; i < NC; i++) begin
            if (i == drop) continue;
            Input_valid = 1'b1;
            Input_index = i[3:0];
            Input_last = (i == NC - 1);
            Input_data[0] = DW'(base + i);
            Input_data[1] = DW'(-(base + i));
            @(posedge Clk);
            #1;
        end
        Input_valid = 1'b0;
        Input_last = 1'b0;
    endtask

    task automatic wait_outputs(input int target, input int budget, input string tag);
        int t = 0;
        while (n_out < target && t < budget) begin
            @(posedge Clk);
            t++;
        end
        #1;
        checks++;
        if (n_out < target) begin
            failures++;
            $display("FAIL %s_timeout got=%0d samples required=%0d", tag, n_out, target);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({Output_valid, Output_last, Output_index, Output_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0",
                     {Output_valid, Output_last, Output_index, Output_data});
        end
        checks++;
        if (Frames_buffered !== 3'd0) begin
            failures++;
            $display("FAIL reset_fill got=%0d required=0", Frames_buffered);
        end
        checks++;
        if ({Error_overflow, Error_underflow, Error_sequence} !== 3'b000) begin
            failures++;
            $display("FAIL reset_errors got=%b required=000",
                     {Error_overflow, Error_underflow, Error_sequence});
        end
    endtask

    task automatic test_nominal();
        int b;
        int e0;
        do_reset();
        b = n_out;
        e0 = n_ovf + n_uf + n_seq;
        Transmit_active = 1'b1;
        send_frame(0, -1);
        repeat (48) @(posedge Clk);
        #1;
        checks++;
        if (n_out !== b) begin
            failures++;
            $display("FAIL nominal_prefill_hold got=%0d samples required=0", n_out - b);
        end
        for (int f = 1; f < 5; f++) begin
            send_frame(0, -1);
            repeat (48) @(posedge Clk);
            #1;
        end
        wait_outputs(b + 64, 200, "nominal");
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (o_idx[b+k] !== 4'(k % NC) || o_last[b+k] !== (k % NC == NC - 1)) begin
                failures++;
                $display("FAIL nominal_idx[%0d] got=%0d/%b required=%0d/%b", k,
                         o_idx[b+k], o_last[b+k], k % NC, (k % NC == NC - 1));
            end
            checks++;
            if (o_i[b+k] !== DW'(k % NC) || o_q[b+k] !== DW'(-(k % NC))) begin
                failures++;
                $display("FAIL nominal_data[%0d] got=%h/%h required=%h/%h", k,
                         o_i[b+k], o_q[b+k], DW'(k % NC), DW'(-(k % NC)));
            end
            if (k > 0) begin
                checks++;
                if (o_cyc[b+k] - o_cyc[b+k-1] != OI) begin
                    failures++;
                    $display("FAIL nominal_cadence[%0d] got=%0d required=%0d", k,
                             o_cyc[b+k] - o_cyc[b+k-1], OI);
                end
            end
        end
        checks++;
        if (n_ovf + n_uf + n_seq !== e0) begin
            failures++;
            $display("FAIL nominal_errors got=%0d required=0", n_ovf + n_uf + n_seq - e0);
        end
    endtask

    task automatic test_overflow_underflow_stats();
        int b;
        int o0;
        int u0;
        int s0;
        int t;
        do_reset();
        o0 = n_ovf;
        u0 = n_uf;
        s0 = n_seq;
        for (int f = 0; f < 5; f++) send_frame(100 * (f + 1), -1);
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (Frames_buffered !== 3'd4) begin
            failures++;
            $display("FAIL ovf_fill got=%0d required=4", Frames_buffered);
        end
        checks++;
        if (n_ovf - o0 !== 1) begin
            failures++;
            $display("FAIL ovf_pulses got=%0d required=1", n_ovf - o0);
        end
        b = n_out;
        Transmit_active = 1'b1;
        wait_outputs(b + 64, 400, "ovf_replay");
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (o_i[b+k] !== DW'(100 * (k / NC + 1) + k % NC)) begin
                failures++;
                $display("FAIL ovf_data[%0d] got=%0d required=%0d", k,
                         o_i[b+k], 100 * (k / NC + 1) + k % NC);
            end
        end
        t = 0;
        while (n_uf == u0 && t < 20) begin
            @(posedge Clk);
            t++;
        end
        #1;
        checks++;
        if (n_uf - u0 !== 1) begin
            failures++;
            $display("FAIL ovf_then_underflow got=%0d required=1", n_uf - u0);
        end
        checks++;
        if (n_seq !== s0) begin
            failures++;
            $display("FAIL ovf_seq got=%0d required=0", n_seq - s0);
        end
`ifdef SYNTH_STRETCHER_STATS_EN
        checks++;
        if (Stat_overflow_count !== 16'd1 || Stat_underflow_count !== 16'd1
            || Stat_sequence_count !== 16'd0) begin
            failures++;
            $display("FAIL stats got=%0d/%0d/%0d required=1/1/0", Stat_overflow_count,
                     Stat_underflow_count, Stat_sequence_count);
        end
`endif
    endtask

    task automatic test_underflow();
        int b;
        int u0;
        do_reset();
        u0 = n_uf;
        b = n_out;
        Transmit_active = 1'b1;
        send_frame(0, -1);
        send_frame(16, -1);
        wait_outputs(b + 48, 400, "underflow");
        for (int k = 0; k < 48; k++) begin
            checks++;
            if (o_idx[b+k] !== 4'(k % NC) || o_last[b+k] !== (k % NC == NC - 1)) begin
                failures++;
                $display("FAIL uf_idx[%0d] got=%0d/%b required=%0d", k,
                         o_idx[b+k], o_last[b+k], k % NC);
            end
            checks++;
            if (o_i[b+k] !== DW'(k < 32 ? k : 0) || o_q[b+k] !== DW'(k < 32 ? -k : 0)) begin
                failures++;
                $display("FAIL uf_data[%0d] got=%h/%h required=%h", k,
                         o_i[b+k], o_q[b+k], DW'(k < 32 ? k : 0));
            end
            if (k > 0) begin
                checks++;
                if (o_cyc[b+k] - o_cyc[b+k-1] != OI) begin
                    failures++;
                    $display("FAIL uf_cadence[%0d] got=%0d required=%0d", k,
                             o_cyc[b+k] - o_cyc[b+k-1], OI);
                end
            end
        end
        checks++;
        if (n_uf - u0 !== 1) begin
            failures++;
            $display("FAIL uf_pulses got=%0d required=1", n_uf - u0);
        end
        checks++;
        if (!(uf_cyc > o_cyc[b+31] && uf_cyc < o_cyc[b+32])) begin
            failures++;
            $display("FAIL uf_pulse_time got=%0d required=%0d..%0d", uf_cyc,
                     o_cyc[b+31] + 1, o_cyc[b+32] - 1);
        end
    endtask

    task automatic test_sequence();
        int b;
        int s0;
        do_reset();
        s0 = n_seq;
        send_frame(0, 5);
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (n_seq - s0 !== 1) begin
            failures++;
            $display("FAIL seq_pulses got=%0d required=1", n_seq - s0);
        end
        checks++;
        if (Frames_buffered !== 3'd0) begin
            failures++;
            $display("FAIL seq_discard got=%0d required=0", Frames_buffered);
        end
        send_frame(30, -1);
        send_frame(50, -1);
        #1;
        checks++;
        if (Frames_buffered !== 3'd2 || n_seq - s0 !== 1) begin
            failures++;
            $display("FAIL seq_recover got=%0d/%0d required=2/1", Frames_buffered, n_seq - s0);
        end
        b = n_out;
        Transmit_active = 1'b1;
        wait_outputs(b + 16, 200, "seq");
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (o_i[b+k] !== DW'(30 + k)) begin
                failures++;
                $display("FAIL seq_data[%0d] got=%0d required=%0d", k, o_i[b+k], 30 + k);
            end
        end
    endtask

    task automatic test_gating();
        int b;
        do_reset();
        b = n_out;
        Transmit_active = 1'b1;
        send_frame(100, -1);
        send_frame(116, -1);
        wait_outputs(b + 4, 200, "gate_start");
        Transmit_active = 1'b0;
        wait_outputs(b + 16, 200, "gate_end");
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (o_i[b+k] !== DW'(k < 4 ? 100 + k : 0)) begin
                failures++;
                $display("FAIL gate_data[%0d] got=%0d required=%0d", k,
                         o_i[b+k], k < 4 ? 100 + k : 0);
            end
        end
        repeat (40) @(posedge Clk);
        #1;
        checks++;
        if (n_out !== b + 16 || Frames_buffered !== 3'd0) begin
            failures++;
            $display("FAIL gate_idle got=%0d/%0d required=16/0", n_out - b, Frames_buffered);
        end
    endtask

    task automatic test_async_reset();
        int b;
        int s0;
        do_reset();
        b = n_out;
        Transmit_active = 1'b1;
        send_frame(0, -1);
        send_frame(16, -1);
        wait_outputs(b + 2, 200, "areset_start");
        for (int i = 0; i < 8; i++) begin
            Input_valid = 1'b1;
            Input_index = i[3:0];
            Input_data[0] = DW'(32 + i);
            Input_data[1] = DW'(-(32 + i));
            @(posedge Clk);
            #1;
        end
        #3;
        Rst_n = 1'b0;
        Input_valid = 1'b0;
        #1;
        checks++;
        if ({Output_valid, Output_last, Output_index, Output_data, Frames_buffered} !== '0) begin
            failures++;
            $display("FAIL areset_outputs got=%h required=0",
                     {Output_valid, Output_last, Output_index, Output_data, Frames_buffered});
        end
        @(posedge Clk);
        @(posedge Clk);
        #1 Rst_n = 1'b1;
        s0 = n_seq;
        b = n_out;
        send_frame(200, -1);
        send_frame(216, -1);
        wait_outputs(b + 16, 200, "areset_restart");
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (o_i[b+k] !== DW'(200 + k) || o_idx[b+k] !== 4'(k)) begin
                failures++;
                $display("FAIL areset_data[%0d] got=%0d/%0d required=%0d/%0d", k,
                         o_i[b+k], o_idx[b+k], 200 + k, k);
            end
        end
        checks++;
        if (n_seq !== s0) begin
            failures++;
            $display("FAIL areset_seq got=%0d required=0", n_seq - s0);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_overflow_underflow_stats();
        test_underflow();
        test_sequence();
        test_gating();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
